// File: rtl/ahb5_pkg.sv
// Shared AHB5 types and constants for the subordinate memory model and the
// bridge that will reuse the strobe generator.
package ahb5_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'd0,
        TransBusy   = 2'd1,
        TransNonseq = 2'd2,
        TransSeq    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SizeByte  = 3'd0,
        SizeHalf  = 3'd1,
        SizeWord  = 3'd2,
        SizeDword = 3'd3
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StWait = 3'd1,
        StData = 3'd2,
        StErr1 = 3'd3,
        StErr2 = 3'd4
    } ahb5_slv_state_e;

    // Number of byte-lane address bits for a given bus width.
    function automatic int unsigned lane_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/ahb5_strb_gen.sv
// Combinational byte-strobe generator: little-endian lanes selected by the
// low address bits and transfer size, plus misalignment and oversize flags.
module ahb5_strb_gen
    import ahb5_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [lane_bits(DATA_WIDTH)-1:0] addr_lsb_i,
    input  logic [2:0]                       size_i,
    output logic [DATA_WIDTH/8-1:0]          strb_o,
    output logic                             misalign_o,
    output logic                             oversize_o
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned LSB_W = lane_bits(DATA_WIDTH);

    logic [31:0] lo;
    logic [31:0] nbytes;

    always_comb begin
        lo         = 32'(addr_lsb_i);
        nbytes     = 32'd1 << size_i;
        oversize_o = 32'(size_i) > LSB_W;
        misalign_o = (lo & (nbytes - 32'd1)) != 32'd0;
        strb_o     = '0;
        if (!oversize_o) begin
            for (int unsigned i = 0; i < NB; i++) begin
                strb_o[i] = (i >= lo) && (i < lo + nbytes);
            end
        end
    end

endmodule

// File: rtl/ahb5_slave_mem.sv
// AHB5 subordinate memory: pipelined address/data phases, programmable wait
// states, byte-strobed writes and a two-cycle ERROR response.
module ahb5_slave_mem
    import ahb5_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           DEPTH       = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           WAIT_STATES = 0
) (
    input  logic                  Hclk,
    input  logic                  HResetn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned LSB_W = lane_bits(DATA_WIDTH);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_chk_width
        $fatal(1, "ahb5_slave_mem: DATA_WIDTH must be 32 or 64");
    end
    if (WAIT_STATES > 15) begin : g_chk_wait
        $fatal(1, "ahb5_slave_mem: WAIT_STATES must be 0..15");
    end
    if ((BASE_ADDR & ADDR_WIDTH'(NB - 1)) != '0) begin : g_chk_base
        $fatal(1, "ahb5_slave_mem: BASE_ADDR not aligned to the bus width");
    end

    // Bursts need no tracking: every beat carries its own address.
    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HTRANS[0]};

    ahb5_slv_state_e       state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q;
    logic [IDX_W-1:0]      idx_q;
    logic [NB-1:0]         strb_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept;
    logic                  take;
    logic                  addr_err;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] index;
    logic [NB-1:0]         strb;
    logic                  misalign;
    logic                  oversize;

    ahb5_strb_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_strb_gen (
        .addr_lsb_i (HADDR[LSB_W-1:0]),
        .size_i     (HSIZE),
        .strb_o     (strb),
        .misalign_o (misalign),
        .oversize_o (oversize)
    );

    assign accept   = HSEL & HREADY & HTRANS[1];
    assign offset   = HADDR - BASE_ADDR;
    assign index    = offset >> LSB_W;
    assign addr_err = (HADDR < BASE_ADDR) | (index >= ADDR_WIDTH'(DEPTH)) | misalign | oversize;

    // Only states that drive HREADYOUT high can own a new address phase.
    assign take = accept && (state_q == StIdle || state_q == StData || state_q == StErr2);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StData, StErr2: begin
                if (HREADY) begin
                    if (accept) begin
                        if (addr_err) begin
                            state_d = StErr1;
                        end else if (WAIT_STATES > 0) begin
                            state_d = StWait;
                            cnt_d   = 4'(WAIT_STATES);
                        end else begin
                            state_d = StData;
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StData;
                end
            end
            StErr1: state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Hclk or negedge HResetn) begin
        if (!HResetn) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            idx_q   <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take) begin
                write_q <= HWRITE;
                idx_q   <= index[IDX_W-1:0];
                strb_q  <= strb;
            end
        end
    end

    // Reset forces state_q to StIdle asynchronously, so an aborted write never commits.
    always_ff @(posedge Hclk) begin
        if (state_q == StData && write_q && HREADY) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (strb_q[i]) begin
                    mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = '0;
        unique case (state_q)
            StWait: HREADYOUT = 1'b0;
            StData: begin
                if (!write_q) begin
                    HRDATA = mem[idx_q];
                end
            end
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            StErr2: HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb5_slave_mem.sv
// Scoreboard bench: three memories (0, 3 and 5 wait states) on one shared bus
// with a HREADY mux; a monitor checks every completed data phase.
module tb_ahb5_slave_mem;

    typedef struct {
        string       name;
        int          waits;
        logic        resp;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'd0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2;
    logic [2:0]  hburst = 3'd0;
    logic [31:0] hwdata = '0;
    logic        force_lo = 1'b0;
    logic [1:0]  sel = 2'd0;

    logic        rdy0, rdy1, rdy2, resp0, resp1, resp2;
    logic [31:0] rdata0, rdata1, rdata2;
    logic        hready, rdy_m, resp_m;
    logic [31:0] rdata_m;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    assign rdy_m   = (sel == 2'd0) ? rdy0 : (sel == 2'd1) ? rdy1 : rdy2;
    assign resp_m  = (sel == 2'd0) ? resp0 : (sel == 2'd1) ? resp1 : resp2;
    assign rdata_m = (sel == 2'd0) ? rdata0 : (sel == 2'd1) ? rdata1 : rdata2;
    assign hready  = force_lo ? 1'b0 : rdy_m;

    ahb5_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .BASE_ADDR(32'h0),
                     .WAIT_STATES(0)) u_dut0 (
        .Hclk(clk), .HResetn(rst_n), .HSEL(hsel && sel == 2'd0), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(hready), .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0)
    );

    ahb5_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .BASE_ADDR(32'h0),
                     .WAIT_STATES(3)) u_dut1 (
        .Hclk(clk), .HResetn(rst_n), .HSEL(hsel && sel == 2'd1), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(hready), .HREADYOUT(rdy1), .HRESP(resp1), .HRDATA(rdata1)
    );

    ahb5_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .BASE_ADDR(32'h0),
                     .WAIT_STATES(5)) u_dut2 (
        .Hclk(clk), .HResetn(rst_n), .HSEL(hsel && sel == 2'd2), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(hready), .HREADYOUT(rdy2), .HRESP(resp2), .HRDATA(rdata2)
    );

    function automatic int ws_of(input logic [1:0] s);
        return (s == 2'd0) ? 0 : (s == 2'd1) ? 3 : 5;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Packed as {waits, hresp, hrdata} for every completed data phase.
    task automatic monitor();
        exp_t e;
        bit   act = 1'b0;
        int   low = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                act = 1'b0;
                low = 0;
            end else begin
                if (act) begin
                    if (!hready) begin
                        low++;
                    end else begin
                        act = 1'b0;
                        if (sb.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_data_phase: got resp %0b data 0x%0h, expected none",
                                     resp_m, rdata_m);
                        end else begin
                            e = sb.pop_front();
                            chk(e.name, {23'd0, 8'(low), resp_m, rdata_m},
                                {23'd0, 8'(e.waits), e.resp, e.rdata});
                        end
                    end
                end
                if (hsel && hready && htrans[1]) begin
                    act = 1'b1;
                    low = 0;
                end
            end
        end
    endtask

    task automatic wait_ready(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = hready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got HREADY stuck low, expected HREADY high within 64 cycles", name);
        end
    endtask

    task automatic addr_phase(input logic [1:0] trans, input logic wr, input logic [2:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata, input bit err,
                              input logic [31:0] exp_rdata, input string name, input bit push);
        exp_t e;
        if (push) begin
            e.name  = name;
            e.waits = err ? 1 : ws_of(sel);
            e.resp  = err;
            e.rdata = exp_rdata;
            sb.push_back(e);
        end
        hsel   = 1'b1;
        htrans = trans;
        hwrite = wr;
        hsize  = size;
        haddr  = addr;
        wait_ready(name);
        hwdata = wdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz,
                      input bit err, input string nm);
        addr_phase(2'd2, 1'b1, sz, a, d, err, 32'h0, nm, 1'b1);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input bit err,
                      input string nm);
        addr_phase(2'd2, 1'b0, 3'd2, a, 32'h0, err, exp, nm, 1'b1);
    endtask

    task automatic idle();
        hsel   = 1'b0;
        htrans = 2'd0;
        wait_ready("idle");
        hwdata = '0;
    endtask

    initial begin
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: got no end of test, expected finish before 200us");
                $fatal(1, "watchdog");
            end
        join_none

        #2 rst_n = 1'b0;
        #1;
        chk("rst_dut0", {rdy0, resp0, rdata0}, {1'b1, 1'b0, 32'h0});
        chk("rst_dut1", {rdy1, resp1, rdata1}, {1'b1, 1'b0, 32'h0});
        chk("rst_dut2", {rdy2, resp2, rdata2}, {1'b1, 1'b0, 32'h0});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        sel = 2'd0;
        wr(32'h10, 32'hDEADBEEF, 3'd2, 1'b0, "wr_word");
        rd(32'h10, 32'hDEADBEEF, 1'b0, "rd_word");
        idle();

        wr(32'h20, 32'h0000_0000, 3'd2, 1'b0, "wr_zero");
        wr(32'h21, 32'h0000_1100, 3'd0, 1'b0, "wr_byte1");
        wr(32'h22, 32'h0022_0000, 3'd0, 1'b0, "wr_byte2");
        rd(32'h20, 32'h0022_1100, 1'b0, "rd_bytes");
        idle();

        wr(32'h0, 32'h0102_0304, 3'd2, 1'b0, "wr_pre_err");
        rd(32'h400, 32'h0, 1'b1, "rd_out_of_range");
        wr(32'h3, 32'hFFFF_FFFF, 3'd1, 1'b1, "wr_misaligned_half");
        wr(32'h0, 32'hFFFF_FFFF, 3'd3, 1'b1, "wr_oversize");
        rd(32'h0, 32'h0102_0304, 1'b0, "rd_after_err");
        idle();

        wr(32'h8, 32'hA5A5_A5A5, 3'd2, 1'b0, "wr_b2b");
        addr_phase(2'd3, 1'b0, 3'd2, 32'h8, 32'h0, 1'b0, 32'hA5A5_A5A5, "rd_seq_fwd", 1'b1);
        idle();

        // BUSY during a read data phase must not start a transfer.
        rd(32'h10, 32'hDEADBEEF, 1'b0, "rd_before_busy");
        hsel   = 1'b1;
        htrans = 2'd1;
        haddr  = 32'h10;
        hwrite = 1'b0;
        wait_ready("busy");
        @(negedge clk);
        chk("busy_no_xfer", {rdy0, resp0, rdata0}, {1'b1, 1'b0, 32'h0});

        // Selected NONSEQ with HREADY held low must be ignored.
        htrans   = 2'd2;
        force_lo = 1'b1;
        @(posedge clk);
        #1;
        force_lo = 1'b0;
        hsel     = 1'b0;
        htrans   = 2'd0;
        @(negedge clk);
        chk("hready_low_no_accept", {rdy0, resp0, rdata0}, {1'b1, 1'b0, 32'h0});
        @(posedge clk);
        #1;

        sel = 2'd1;
        wr(32'h4, 32'h0BAD_F00D, 3'd2, 1'b0, "wr_ws3");
        rd(32'h4, 32'h0BAD_F00D, 1'b0, "rd_ws3");
        idle();

        sel = 2'd2;
        wr(32'hC, 32'hCAFE_F00D, 3'd2, 1'b0, "wr_ws5_pre");
        idle();
        addr_phase(2'd2, 1'b1, 3'd2, 32'hC, 32'h1234_5678, 1'b0, 32'h0, "wr_aborted", 1'b0);
        hsel   = 1'b0;
        htrans = 2'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wait", {rdy2, resp2, rdata2}, {1'b1, 1'b0, 32'h0});
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(32'hC, 32'hCAFE_F00D, 1'b0, "rd_after_abort");
        idle();

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
